// File: rtl/ps2_key_pkg.sv
// ps2_key_pkg: scancode constants, key indices, tracker FSM states
// and the scancode-to-key mask helper shared by the PS/2 key tracker.
package ps2_key_pkg;

   localparam logic [7:0] CODE_EXT   = 8'hE0;
   localparam logic [7:0] CODE_BRK   = 8'hF0;
   localparam logic [7:0] CODE_PAUSE = 8'hE1;
   localparam logic [7:0] CODE_ENTER = 8'h5A;
   localparam logic [7:0] CODE_LEFT  = 8'h6B;
   localparam logic [7:0] CODE_RIGHT = 8'h74;

   localparam int KEY_ENTER = 2;
   localparam int KEY_LEFT  = 1;
   localparam int KEY_RIGHT = 0;

   localparam logic [2:0] PAUSE_TAIL_BYTES = 3'd7;

   typedef enum logic [2:0] {
      IDLE,
      EXT,
      BRK,
      EXT_BRK,
      SKIP
   } state_t;

   // One-hot key bit for a final scancode; zero for unmapped codes.
   function automatic logic [2:0] key_mask(input logic [7:0] code);
      logic [2:0] m;
      m = '0;
      case (code)
         CODE_ENTER: m[KEY_ENTER] = 1'b1;
         CODE_LEFT:  m[KEY_LEFT]  = 1'b1;
         CODE_RIGHT: m[KEY_RIGHT] = 1'b1;
         default:    m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ps2_key_tracker_timer.sv
// ps2_seq_timer: inter-byte stall counter; clear zeroes it, enable
// advances it (saturating), expired flags the last count for one cycle.
// Ports: clk, reset (sync, high), clear, enable in; expired out.
module ps2_seq_timer #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && (count != LAST)) begin
         count <= count + W'(1);
      end
   end

   // A byte arriving on the expiry cycle wins over the timeout.
   assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: parses PS/2 set-2 make/break/E0/E1 sequences into
// held levels and press/release pulses for Enter, Left and Right.
// Ports: CLOCK_50, reset (sync, high), received_data[7:0],
// received_data_en in; key_held, key_press, key_release [2:0]
// (bit2 Enter, bit1 Left, bit0 Right) and seq_error out.
module ps2_key_tracker
   import ps2_key_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [7:0] received_data,
   input  logic       received_data_en,
   output logic [2:0] key_held,
   output logic [2:0] key_press,
   output logic [2:0] key_release,
   output logic       seq_error
);

   state_t     state;
   state_t     nstate;
   logic [2:0] skip;
   logic [2:0] nskip;
   logic [2:0] hit;
   logic       err;
   logic       make;
   logic       brk;
   logic       rehandle;
   logic       expired;

   ps2_seq_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (CLOCK_50),
      .reset  (reset),
      .clear  (received_data_en),
      .enable (state != IDLE),
      .expired(expired)
   );

   assign hit = key_mask(received_data);

   // Byte decode: a bad prefix flags an error and the byte is then
   // treated as the start of a fresh sequence.
   always_comb begin
      nstate   = state;
      nskip    = skip;
      err      = 1'b0;
      make     = 1'b0;
      brk      = 1'b0;
      rehandle = 1'b0;
      unique case (state)
         IDLE: rehandle = 1'b1;
         EXT: begin
            if (received_data == CODE_BRK) begin
               nstate = EXT_BRK;
            end else if (received_data == CODE_EXT ||
                         received_data == CODE_PAUSE) begin
               err      = 1'b1;
               rehandle = 1'b1;
            end else begin
               make   = 1'b1;
               nstate = IDLE;
            end
         end
         BRK, EXT_BRK: begin
            if (received_data == CODE_EXT ||
                received_data == CODE_BRK ||
                received_data == CODE_PAUSE) begin
               err      = 1'b1;
               rehandle = 1'b1;
            end else begin
               brk    = 1'b1;
               nstate = IDLE;
            end
         end
         SKIP: begin
            nskip = skip - 3'd1;
            if (skip <= 3'd1) begin
               nskip  = '0;
               nstate = IDLE;
            end
         end
      endcase
      if (rehandle) begin
         case (received_data)
            CODE_EXT:   nstate = EXT;
            CODE_BRK:   nstate = BRK;
            CODE_PAUSE: begin
               nstate = SKIP;
               nskip  = PAUSE_TAIL_BYTES;
            end
            default: begin
               nstate = IDLE;
               make   = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state       <= IDLE;
         skip        <= '0;
         key_held    <= '0;
         key_press   <= '0;
         key_release <= '0;
         seq_error   <= 1'b0;
      end else begin
         key_press   <= '0;
         key_release <= '0;
         seq_error   <= 1'b0;
         if (received_data_en) begin
            state     <= nstate;
            skip      <= nskip;
            seq_error <= err;
            if (make) begin
               key_held  <= key_held | hit;
               key_press <= hit & ~key_held;
            end
            if (brk) begin
               key_held    <= key_held & ~hit;
               key_release <= hit & key_held;
            end
         end else if (expired) begin
            state     <= IDLE;
            skip      <= '0;
            seq_error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: scoreboard bench for ps2_key_tracker; each byte
// pushes its expected outputs, a monitor pops them one cycle later.
module tb_ps2_key_tracker;
   import ps2_key_pkg::*;

   localparam int T = 64;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] received_data;
   logic       received_data_en;
   logic [2:0] key_held;
   logic [2:0] key_press;
   logic [2:0] key_release;
   logic       seq_error;

   typedef struct packed {
      logic [2:0] held;
      logic [2:0] press;
      logic [2:0] rel;
      logic       err;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   vectors = 0;
   int   miscompares = 0;
   logic en_d = 1'b0;
   bit   quiet = 1'b0;
   int   first;
   int   pulses;

   always #5 clk = ~clk;

   ps2_key_tracker #(
      .TIMEOUT_CYCLES(T)
   ) dut (
      .CLOCK_50        (clk),
      .reset           (reset),
      .received_data   (received_data),
      .received_data_en(received_data_en),
      .key_held        (key_held),
      .key_press       (key_press),
      .key_release     (key_release),
      .seq_error       (seq_error)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic [2:0] h,
                       input logic [2:0] p, input logic [2:0] r,
                       input logic er);
      sb.push_back(exp_t'{h, p, r, er});
      @(posedge clk);
      #1 received_data = b;
      received_data_en = 1'b1;
      @(posedge clk);
      #1 received_data_en = 1'b0;
   endtask

   task automatic gap();
      repeat (3) @(posedge clk);
   endtask

   always @(posedge clk) en_d <= received_data_en;

   always @(negedge clk) begin
      if (en_d) begin
         chk("sb_depth", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("held", key_held, e.held);
            chk("press", key_press, e.press);
            chk("release", key_release, e.rel);
            chk("seq_err", seq_error, e.err);
            quiet = 1'b1;
         end
      end else if (quiet) begin
         chk("press_1cyc", key_press, 0);
         chk("release_1cyc", key_release, 0);
         chk("err_1cyc", seq_error, 0);
         quiet = 1'b0;
      end
   end

   initial begin
      reset = 1'b1;
      received_data = 8'h00;
      received_data_en = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_held", key_held, 0);
      chk("rst_press", key_press, 0);
      chk("rst_release", key_release, 0);
      chk("rst_err", seq_error, 0);

      // Enter make, typematic repeat, break
      send(CODE_ENTER, 3'b100, 3'b100, 3'b000, 1'b0); gap();
      send(CODE_ENTER, 3'b100, 3'b000, 3'b000, 1'b0); gap();
      send(CODE_BRK,   3'b100, 3'b000, 3'b000, 1'b0); gap();
      send(CODE_ENTER, 3'b000, 3'b000, 3'b100, 1'b0); gap();

      // Extended Left make and break
      send(CODE_EXT,  3'b000, 3'b000, 3'b000, 1'b0); gap();
      send(CODE_LEFT, 3'b010, 3'b010, 3'b000, 1'b0); gap();
      send(CODE_EXT,  3'b010, 3'b000, 3'b000, 1'b0); gap();
      send(CODE_BRK,  3'b010, 3'b000, 3'b000, 1'b0); gap();
      send(CODE_LEFT, 3'b000, 3'b000, 3'b010, 1'b0); gap();

      // Stalled break prefix times out
      send(CODE_BRK, 3'b000, 3'b000, 3'b000, 1'b0);
      first = -1;
      pulses = 0;
      for (int k = 1; k <= T + 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (seq_error) begin
            pulses++;
            if (first < 0) first = k;
         end
      end
      chk("to_cycle", first, T);
      chk("to_pulses", pulses, 1);
      chk("to_held", key_held, 0);
      send(CODE_RIGHT, 3'b001, 3'b001, 3'b000, 1'b0); gap();

      // Pause sequence is skipped without decoding
      send(CODE_PAUSE, 3'b001, 3'b000, 3'b000, 1'b0); gap();
      send(8'h14,      3'b001, 3'b000, 3'b000, 1'b0); gap();
      send(8'h77,      3'b001, 3'b000, 3'b000, 1'b0); gap();
      send(CODE_PAUSE, 3'b001, 3'b000, 3'b000, 1'b0); gap();
      send(CODE_BRK,   3'b001, 3'b000, 3'b000, 1'b0); gap();
      send(8'h14,      3'b001, 3'b000, 3'b000, 1'b0); gap();
      send(CODE_BRK,   3'b001, 3'b000, 3'b000, 1'b0); gap();
      send(8'h77,      3'b001, 3'b000, 3'b000, 1'b0); gap();
      send(CODE_ENTER, 3'b101, 3'b100, 3'b000, 1'b0); gap();

      // Doubled break prefix flags an error, then releases
      send(CODE_BRK,   3'b101, 3'b000, 3'b000, 1'b0); gap();
      send(CODE_BRK,   3'b101, 3'b000, 3'b000, 1'b1); gap();
      send(CODE_ENTER, 3'b001, 3'b000, 3'b100, 1'b0); gap();

      // Reset mid-sequence discards the prefix
      send(CODE_EXT, 3'b001, 3'b000, 3'b000, 1'b0); gap();
      send(CODE_BRK, 3'b001, 3'b000, 3'b000, 1'b0); gap();
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_held", key_held, 0);
      chk("mid_rst_press", key_press, 0);
      chk("mid_rst_release", key_release, 0);
      chk("mid_rst_err", seq_error, 0);
      send(CODE_LEFT, 3'b010, 3'b010, 3'b000, 1'b0); gap();

      // Byte landing on the expiry cycle wins over the timeout
      send(CODE_BRK, 3'b010, 3'b000, 3'b000, 1'b0);
      repeat (T - 2) @(posedge clk);
      send(CODE_LEFT, 3'b000, 3'b000, 3'b010, 1'b0); gap();

      gap();
      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
